// File: rtl/gshare_mp.sv
// gshare_mp: multi-port gshare direction predictor.
// Predicts up to PRED_PORTS slots per cycle from a table of saturating
// counters indexed by PC xor speculative global history. The table is swept
// to weakly-not-taken after reset, updates use a two-stage read-modify-write
// with same-index forwarding, and flushes repair the speculative history.
// Optional macro GSHARE_PERF_CNT_EN adds update/flush event counters.
module gshare_mp #(
    parameter int HISTORY_BITS = 8,
    parameter int SIZE         = 1024,
    parameter int CTR_BITS     = 2,
    parameter int PRED_PORTS   = 2,
    parameter int PC_SHIFT     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PRED_PORTS*32-1:0]     pc_in,
    input  logic [PRED_PORTS*2-1:0]      br_type,
    output logic [PRED_PORTS-1:0]        is_taken_out,
    output logic [HISTORY_BITS-1:0]      ghr_out,
    output logic                         init_busy,
    input  logic                         wr_en,
    input  logic [31:0]                  orig_pc,
    input  logic [HISTORY_BITS-1:0]      upd_ghr,
    input  logic                         is_taken,
    input  logic                         must_flush,
    input  logic [HISTORY_BITS-1:0]      flush_ghr,
    input  logic                         flush_taken
`ifdef GSHARE_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_upd_cnt,
    output logic [31:0]                  perf_flush_cnt
`endif
);

    localparam int IDX = $clog2(SIZE);
    localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [IDX-1:0]          init_idx;
    logic [CTR_BITS-1:0]     ctr_table [SIZE];
    logic [HISTORY_BITS-1:0] spec_ghr;
    logic [HISTORY_BITS-1:0] ghr_adv;
    logic                    walk_stop;
    logic                    run;
    logic                    upd_accept;
    logic                    flush_accept;
    logic [IDX-1:0]          upd_idx;
    logic [CTR_BITS-1:0]     upd_cur;
    logic                    u2_valid;
    logic                    u2_taken;
    logic [IDX-1:0]          u2_idx;
    logic [CTR_BITS-1:0]     u2_old;
    logic [CTR_BITS-1:0]     u2_new;

    // PC bits above the dropped offset, with the low history-wide part hashed by h
    function automatic logic [IDX-1:0] index_of(input logic [31:0] pc,
                                                 input logic [HISTORY_BITS-1:0] h);
        logic [IDX-1:0] r;
        r = IDX'(pc >> PC_SHIFT);
        r[HISTORY_BITS-1:0] = r[HISTORY_BITS-1:0] ^ h;
        return r;
    endfunction

    assign run          = (state == ST_RUN);
    assign upd_accept   = run & wr_en;
    assign flush_accept = run & must_flush;
    assign upd_idx      = index_of(orig_pc, upd_ghr);
    assign ghr_out      = spec_ghr;
    assign init_busy    = (state == ST_INIT);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= state_next;
    end

    // Leave the sweep once the last entry has been written
    always_comb begin
        state_next = state;
        if (state == ST_INIT && init_idx == IDX'(SIZE - 1)) state_next = ST_RUN;
    end

    // Sweep pointer walks one entry per cycle during INIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                init_idx <= '0;
        else if (state == ST_INIT) init_idx <= init_idx + IDX'(1);
    end

    // Per-slot predictions; conditionals read as not-taken until the table is valid
    always_comb begin
        is_taken_out = '0;
        for (int i = 0; i < PRED_PORTS; i++) begin
            if (br_type[2*i+1])
                is_taken_out[i] = rst_n;
            else if (br_type[2*i])
                is_taken_out[i] = run & ctr_table[index_of(pc_in[32*i +: 32], spec_ghr)][CTR_BITS-1];
        end
    end

    // History advance along the predicted path, stopping after the first taken slot
    always_comb begin
        ghr_adv   = spec_ghr;
        walk_stop = 1'b0;
        for (int i = 0; i < PRED_PORTS; i++) begin
            if (!walk_stop) begin
                if (br_type[2*i+1]) begin
                    walk_stop = 1'b1;
                end else if (br_type[2*i]) begin
                    ghr_adv   = {ghr_adv[HISTORY_BITS-2:0], is_taken_out[i]};
                    walk_stop = is_taken_out[i];
                end
            end
        end
    end

    // Speculative history: held at zero during the sweep, flush wins over advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            spec_ghr <= '0;
        else if (!run)         spec_ghr <= '0;
        else if (flush_accept) spec_ghr <= {flush_ghr[HISTORY_BITS-2:0], flush_taken};
        else                   spec_ghr <= ghr_adv;
    end

    // U1 read takes the U2 result when both touch the same entry
    always_comb begin
        upd_cur = ctr_table[upd_idx];
        if (u2_valid && u2_idx == upd_idx) upd_cur = u2_new;
    end

    // U2 saturating modify of the value captured in U1
    always_comb begin
        u2_new = u2_old;
        if (u2_taken) begin
            if (u2_old != CTR_MAX) u2_new = u2_old + CTR_BITS'(1);
        end else begin
            if (u2_old != '0) u2_new = u2_old - CTR_BITS'(1);
        end
    end

    // U1 -> U2 pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u2_valid <= 1'b0;
            u2_taken <= 1'b0;
            u2_idx   <= '0;
            u2_old   <= '0;
        end else begin
            u2_valid <= upd_accept;
            u2_taken <= is_taken;
            u2_idx   <= upd_idx;
            u2_old   <= upd_cur;
        end
    end

    // Single table write port shared by the sweep and the U2 write-back
    always_ff @(posedge clk) begin
        if (state == ST_INIT)  ctr_table[init_idx] <= CTR_WEAK_NT;
        else if (u2_valid)     ctr_table[u2_idx]   <= u2_new;
    end

`ifdef GSHARE_PERF_CNT_EN
    // Event counters for accepted updates and flushes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_upd_cnt   <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (upd_accept)   perf_upd_cnt   <= perf_upd_cnt + 32'd1;
            if (flush_accept) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gshare_mp.sv
// tb_gshare_mp: randomized scoreboard bench for gshare_mp.
// A driver applies one stimulus vector per cycle and pushes the response
// predicted by a behavioural model; a monitor pops and compares on negedge.
module tb_gshare_mp;

    localparam int H    = 8;
    localparam int SZ   = 256;
    localparam int CB   = 2;
    localparam int PP   = 2;
    localparam int PS   = 2;
    localparam int CMAX = (1 << CB) - 1;
    localparam int WEAK = (1 << (CB - 1)) - 1;

    logic            clk;
    logic            rst_n;
    logic [PP*32-1:0] pc_in;
    logic [PP*2-1:0] br_type;
    logic [PP-1:0]   is_taken_out;
    logic [H-1:0]    ghr_out;
    logic            init_busy;
    logic            wr_en;
    logic [31:0]     orig_pc;
    logic [H-1:0]    upd_ghr;
    logic            is_taken;
    logic            must_flush;
    logic [H-1:0]    flush_ghr;
    logic            flush_taken;
`ifdef GSHARE_PERF_CNT_EN
    logic [31:0]     perf_upd_cnt;
    logic [31:0]     perf_flush_cnt;
`endif

    gshare_mp #(
        .HISTORY_BITS(H), .SIZE(SZ), .CTR_BITS(CB), .PRED_PORTS(PP), .PC_SHIFT(PS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .br_type(br_type),
        .is_taken_out(is_taken_out), .ghr_out(ghr_out), .init_busy(init_busy),
        .wr_en(wr_en), .orig_pc(orig_pc), .upd_ghr(upd_ghr), .is_taken(is_taken),
        .must_flush(must_flush), .flush_ghr(flush_ghr), .flush_taken(flush_taken)
`ifdef GSHARE_PERF_CNT_EN
        , .perf_upd_cnt(perf_upd_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PP-1:0] tk;
        logic [H-1:0]  ghr;
        logic          busy;
        logic [31:0]   pu;
        logic [31:0]   pf;
        int            cyc;
    } exp_t;

    typedef struct {
        int idx;
        bit tk;
        int due;
    } upd_t;

    exp_t        exp_q[$];
    upd_t        pend[$];
    int          cnt[SZ];
    int          m_ghr;
    int          init_left;
    int          cyc;
    int unsigned m_pu;
    int unsigned m_pf;
    int          n_vec;
    int          n_bad;

    // Table slot a branch maps to: PC word address modulo table size, low bits hashed with history
    function automatic int m_index(input logic [31:0] pc, input int h);
        return int'((pc >> PS) % SZ) ^ h;
    endfunction

    // Model predictions for the inputs currently on the bus
    function automatic logic [PP-1:0] m_preds();
        logic [PP-1:0] p;
        logic [1:0]    bt;
        p = '0;
        for (int i = 0; i < PP; i++) begin
            bt = br_type[2*i +: 2];
            if (!rst_n)
                p[i] = 1'b0;
            else if (bt[1])
                p[i] = 1'b1;
            else if (bt == 2'b01 && init_left == 0)
                p[i] = (cnt[m_index(pc_in[32*i +: 32], m_ghr)] > WEAK);
        end
        return p;
    endfunction

    task automatic model_reset();
        m_ghr     = 0;
        init_left = SZ;
        pend.delete();
        m_pu      = 0;
        m_pf      = 0;
    endtask

    // Model state change at the clock edge closing the current cycle
    task automatic model_edge();
        logic [PP-1:0] p;
        upd_t          u;
        p = m_preds();
        if (!rst_n) return;
        if (init_left > 0) begin
            init_left--;
            if (init_left == 0) foreach (cnt[k]) cnt[k] = WEAK;
            return;
        end
        if (must_flush) begin
            m_ghr = (int'(flush_ghr) * 2 + int'(flush_taken)) % (1 << H);
            m_pf++;
        end else begin
            for (int i = 0; i < PP; i++) begin
                if (br_type[2*i+1]) break;
                if (br_type[2*i]) begin
                    m_ghr = (m_ghr * 2 + int'(p[i])) % (1 << H);
                    if (p[i]) break;
                end
            end
        end
        while (pend.size() > 0 && pend[0].due == cyc) begin
            u = pend.pop_front();
            if (u.tk) cnt[u.idx] = (cnt[u.idx] < CMAX) ? cnt[u.idx] + 1 : CMAX;
            else      cnt[u.idx] = (cnt[u.idx] > 0) ? cnt[u.idx] - 1 : 0;
        end
        if (wr_en) begin
            u.idx = m_index(orig_pc, int'(upd_ghr));
            u.tk  = is_taken;
            u.due = cyc + 1;
            pend.push_back(u);
            m_pu++;
        end
    endtask

    task automatic apply_stimulus(input logic rst, input logic [63:0] pcs, input logic [3:0] bt,
                                  input logic we, input logic [31:0] opc, input logic [7:0] ug,
                                  input logic tk, input logic mf, input logic [7:0] fg,
                                  input logic ft);
        exp_t e;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        rst_n = rst; pc_in = pcs; br_type = bt; wr_en = we; orig_pc = opc;
        upd_ghr = ug; is_taken = tk; must_flush = mf; flush_ghr = fg; flush_taken = ft;
        if (!rst) model_reset();
        e.tk   = m_preds();
        e.ghr  = H'(m_ghr);
        e.busy = (init_left > 0);
        e.pu   = m_pu;
        e.pf   = m_pf;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] rand_pc();
        return ($urandom() & 32'hFFFF_FC00) | 32'h100 | (32'($urandom_range(0, 15)) << 2)
               | 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [1:0] rand_bt();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return 2'b00;
        if (r < 8) return 2'b01;
        return (r == 8) ? 2'b10 : 2'b11;
    endfunction

    task automatic rand_cycle(input logic rst);
        logic [7:0] fg;
        fg = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
        apply_stimulus(rst, {rand_pc(), rand_pc()}, {rand_bt(), rand_bt()},
                       $urandom_range(0, 2) == 0, rand_pc(), 8'($urandom_range(0, 3)),
                       $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, fg,
                       1'($urandom_range(0, 1)));
    endtask

    task automatic dir(input logic [31:0] pc0, input logic [1:0] bt0, input logic [31:0] pc1,
                       input logic [1:0] bt1, input logic we, input logic [31:0] opc,
                       input logic tk, input logic mf, input logic [7:0] fg, input logic ft);
        apply_stimulus(1'b1, {pc1, pc0}, {bt1, bt0}, we, opc, 8'h00, tk, mf, fg, ft);
    endtask

    task automatic idle();
        dir(32'h0, 2'b00, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic flush_to(input logic [7:0] fg, input logic ft);
        dir(32'h0, 2'b00, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, fg, ft);
    endtask

    task automatic check_one(input string nm, input logic [31:0] act, input logic [31:0] exp_v,
                             input int c);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("[TB] FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", nm, c, act, exp_v);
        end
    endtask

    task automatic check_output(input exp_t e);
        check_one("is_taken_out", 32'(is_taken_out), 32'(e.tk), e.cyc);
        check_one("ghr_out", 32'(ghr_out), 32'(e.ghr), e.cyc);
        check_one("init_busy", 32'(init_busy), 32'(e.busy), e.cyc);
`ifdef GSHARE_PERF_CNT_EN
        check_one("perf_upd_cnt", perf_upd_cnt, e.pu, e.cyc);
        check_one("perf_flush_cnt", perf_flush_cnt, e.pf, e.cyc);
`endif
    endtask

    // Monitor: compare the DUT against the oldest expectation each negedge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    end

    // Watchdog against a stalled run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Driver
    initial begin
        n_vec = 0; n_bad = 0; cyc = 0;
        rst_n = 1'b0; pc_in = '0; br_type = '0; wr_en = 1'b0; orig_pc = '0; upd_ghr = '0;
        is_taken = 1'b0; must_flush = 1'b0; flush_ghr = '0; flush_taken = 1'b0;
        foreach (cnt[k]) cnt[k] = WEAK;
        model_reset();

        // reset held with unconditional branches on the bus
        repeat (3) apply_stimulus(1'b0, {rand_pc(), rand_pc()}, 4'b1110, 1'b1, rand_pc(),
                                  8'h00, 1'b1, 1'b1, 8'h5A, 1'b1);
        // sweep partially done, updates and flushes must be ignored
        repeat (30) rand_cycle(1'b1);
        // reset mid-sweep, then a full sweep again
        repeat (2) rand_cycle(1'b0);
        repeat (SZ + 2) rand_cycle(1'b1);

        // training at pc 0x100 with history 0, saturating at the top
        flush_to(8'h00, 1'b0);
        repeat (3) dir(32'h100, 2'b01, 32'h0, 2'b00, 1'b1, 32'h100, 1'b1, 1'b0, 8'h00, 1'b0);
        repeat (2) idle();
        flush_to(8'h00, 1'b0);
        dir(32'h100, 2'b01, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);

        // back-to-back updates to one entry, then a decrement exposes a lost step
        repeat (2) dir(32'h0, 2'b00, 32'h0, 2'b00, 1'b1, 32'h200, 1'b1, 1'b0, 8'h00, 1'b0);
        dir(32'h0, 2'b00, 32'h0, 2'b00, 1'b1, 32'h200, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (2) idle();
        flush_to(8'h00, 1'b0);
        dir(32'h200, 2'b01, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);

        // history groups: not-taken then taken, taken first, unconditional first
        flush_to(8'h00, 1'b0);
        dir(32'h300, 2'b01, 32'h100, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);
        idle();
        flush_to(8'h00, 1'b0);
        dir(32'h100, 2'b01, 32'h300, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);
        idle();
        flush_to(8'h00, 1'b0);
        dir(32'h0, 2'b10, 32'h100, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);
        idle();

        // flush beats a same-cycle lookup advance
        dir(32'h100, 2'b01, 32'h300, 2'b01, 1'b0, 32'h0, 1'b0, 1'b1, 8'h5A, 1'b1);
        idle();

        repeat (3000) rand_cycle(1'b1);

        // reset during normal operation
        repeat (2) rand_cycle(1'b0);
        repeat (SZ + 20) rand_cycle(1'b1);

        // let the monitor drain the scoreboard
        repeat (4) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
